// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty controller.
// Imported by the controller, its shadow register and its config interface.
package pwm_pkg;

  localparam int BITS_DEF = 4;
  localparam logic [BITS_DEF-1:0] PERIOD_RST_DEF = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Configuration valid/ready channel for the PWM duty controller.
// The master offers period/duty; the slave answers with ready.
interface pwm_duty_ctrl_if
  import pwm_pkg::*;
#(
  parameter int BITS = BITS_DEF
);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [BITS-1:0] cfg_period;
  logic [BITS-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );

endinterface

// File: rtl/pwm_shadow_reg.sv
// Pending/active period and duty register pair.
// Active values change only by direct load or by applying the pending pair.
module pwm_shadow_reg
  import pwm_pkg::*;
#(
  parameter int              BITS       = BITS_DEF,
  parameter logic [BITS-1:0] PERIOD_RST = {BITS{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_direct,
  input  logic            load_pending,
  input  logic            apply,
  input  logic [BITS-1:0] period_in,
  input  logic [BITS-1:0] duty_in,
  output logic [BITS-1:0] period_act,
  output logic [BITS-1:0] duty_act,
  output logic            pending
);

  logic [BITS-1:0] period_pnd;
  logic [BITS-1:0] duty_pnd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_act <= PERIOD_RST;
      duty_act   <= '0;
      period_pnd <= '0;
      duty_pnd   <= '0;
      pending    <= 1'b0;
    end else begin
      if (load_direct) begin
        period_act <= period_in;
        duty_act   <= duty_in;
      end else if (apply) begin
        period_act <= period_pnd;
        duty_act   <= duty_pnd;
        pending    <= 1'b0;
      end
      if (load_pending) begin
        period_pnd <= period_in;
        duty_pnd   <= duty_in;
        pending    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// PWM control stage: start/stop FSM, counter drive, duty compare.
// Period/duty updates are double-buffered to land on a period boundary.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int              BITS       = BITS_DEF,
  parameter logic [BITS-1:0] PERIOD_RST = {BITS{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  pwm_duty_ctrl_if.slave  cfg,
  input  logic [BITS-1:0] cnt_q,
  output logic            cnt_enable,
  output logic [BITS-1:0] cnt_final,
  output logic            pwm_out,
  output logic            period_tick,
  output logic            busy
);

  state_t          state;
  state_t          state_nx;
  logic [BITS-1:0] period_act;
  logic [BITS-1:0] duty_act;
  logic            pending;
  logic            xfer;
  logic            wrap;
  logic            idle;

  assign idle       = (state == ST_IDLE);
  assign busy       = !idle;
  assign cnt_enable = busy;
  assign cnt_final  = period_act;
  assign wrap       = cnt_enable && (cnt_q == period_act);
  assign period_tick = wrap;
  assign pwm_out    = busy && (cnt_q < duty_act);

  assign cfg.cfg_ready = !pending;
  assign xfer          = cfg.cfg_valid && !pending;

  // A pending pair left over in IDLE (accepted on the final DRAIN wrap)
  // is applied right away so cfg_ready cannot stay low while idle.
  pwm_shadow_reg #(
    .BITS       (BITS),
    .PERIOD_RST (PERIOD_RST)
  ) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .load_direct  (xfer && idle),
    .load_pending (xfer && !idle),
    .apply        (pending && (wrap || idle)),
    .period_in    (cfg.cfg_period),
    .duty_in      (cfg.cfg_duty),
    .period_act   (period_act),
    .duty_act     (duty_act),
    .pending      (pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == ST_RUN): begin
        if (stop) state_nx = ST_DRAIN;
      end
      (state == ST_DRAIN): begin
        if (start)     state_nx = ST_RUN;
        else if (wrap) state_nx = ST_IDLE;
      end
      default: begin
        if (start) state_nx = ST_RUN;
        else       state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with a behavioural modulo counter.
// Expected outputs per cycle are queued at drive time, checked at negedge.
module tb_pwm_duty_ctrl;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       pwm;
    logic       tick;
    logic       busy;
    logic       rdy;
    logic [3:0] fin;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] cnt_q;
  logic       cnt_enable;
  logic [3:0] cnt_final;
  logic       pwm_out;
  logic       period_tick;
  logic       busy;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t e;
  logic [3:0] fin = 4'd15;

  pwm_duty_ctrl_if #(.BITS(4)) cfg_if ();

  pwm_duty_ctrl #(.BITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .cfg         (cfg_if),
    .cnt_q       (cnt_q),
    .cnt_enable  (cnt_enable),
    .cnt_final   (cnt_final),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt_q <= '0;
    else if (cnt_enable)        cnt_q <= (cnt_q == cnt_final) ? 4'd0 : cnt_q + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, " cnt_q"}, 32'(cnt_q), 32'(e.cnt));
      chk({e.tag, " pwm_out"}, 32'(pwm_out), 32'(e.pwm));
      chk({e.tag, " period_tick"}, 32'(period_tick), 32'(e.tick));
      chk({e.tag, " busy"}, 32'(busy), 32'(e.busy));
      chk({e.tag, " cnt_enable"}, 32'(cnt_enable), 32'(e.busy));
      chk({e.tag, " cfg_ready"}, 32'(cfg_if.cfg_ready), 32'(e.rdy));
      chk({e.tag, " cnt_final"}, 32'(cnt_final), 32'(e.fin));
    end
  end

  task automatic cyc(input string tag, input logic r, st, sp, v,
                     input logic [3:0] per, dut_v,
                     input logic [3:0] ec, input logic ep, et, eb, er);
    @(posedge clk);
    #1;
    reset = r;
    start = st;
    stop = sp;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_period = per;
    cfg_if.cfg_duty = dut_v;
    sb.push_back('{tag: tag, cnt: ec, pwm: ep, tick: et, busy: eb, rdy: er, fin: fin});
  endtask

  task automatic per_run(input string tag, input int p, input int d);
    for (int k = 0; k <= p; k++)
      cyc(tag, 0, 0, 0, 0, 0, 0, 4'(k), k < d, k == p, 1, 1);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty = '0;
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("go", 0, 1, 0, 1, 4, 2, 0, 0, 0, 0, 1);
    fin = 4;
    per_run("basic", 4, 2);
    per_run("basic", 4, 2);
    cyc("upd", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    cyc("upd", 0, 0, 0, 1, 2, 1, 1, 1, 0, 1, 1);
    cyc("upd_busy", 0, 0, 0, 1, 7, 7, 2, 0, 0, 1, 0);
    cyc("upd_busy", 0, 0, 0, 1, 7, 7, 3, 0, 0, 1, 0);
    cyc("upd_busy", 0, 0, 0, 1, 7, 7, 4, 0, 1, 1, 0);
    fin = 2;
    per_run("upd_new", 2, 1);
    per_run("upd_new", 2, 1);
    cyc("back", 0, 0, 0, 1, 4, 2, 0, 1, 0, 1, 1);
    cyc("back", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    cyc("back", 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0);
    fin = 4;
    cyc("stop", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    cyc("stop", 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1);
    cyc("drain", 0, 0, 1, 0, 0, 0, 2, 0, 0, 1, 1);
    cyc("drain", 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    cyc("drain", 0, 0, 0, 0, 0, 0, 4, 0, 1, 1, 1);
    cyc("parked", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("parked", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("parked", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("cancel", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("cancel", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    cyc("cancel", 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1);
    cyc("cancel", 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1);
    cyc("cancel", 0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    cyc("cancel", 0, 0, 0, 0, 0, 0, 4, 0, 1, 1, 1);
    cyc("cancel", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    cyc("cancel", 0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    cyc("cancel", 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1);
    cyc("cancel", 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    cyc("cancel", 0, 0, 0, 0, 0, 0, 4, 0, 1, 1, 1);
    cyc("duty0_cfg", 0, 0, 0, 1, 4, 0, 0, 1, 0, 1, 1);
    cyc("duty0_cfg", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    for (int k = 2; k <= 4; k++)
      cyc("duty0_cfg", 0, 0, 0, 0, 0, 0, 4'(k), 0, k == 4, 1, 0);
    cyc("duty0", 0, 0, 0, 1, 4, 5, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 4; k++)
      cyc("duty0", 0, 0, 0, 0, 0, 0, 4'(k), 0, k == 4, 1, 0);
    cyc("duty5", 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1);
    for (int k = 1; k <= 4; k++)
      cyc("duty5", 0, 0, 0, 0, 0, 0, 4'(k), 1, k == 4, 1, 0);
    fin = 0;
    for (int k = 0; k < 4; k++)
      cyc("per0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    cyc("per0", 0, 0, 0, 1, 4, 2, 0, 1, 1, 1, 1);
    cyc("per0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    fin = 4;
    cyc("pre_rst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    cyc("pre_rst", 0, 0, 0, 1, 3, 3, 1, 1, 0, 1, 1);
    fin = 15;
    cyc("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("post_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++)
      cyc("post_rst", 0, 0, 0, 0, 0, 0, 4'(k), 0, 0, 1, 1);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
